// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the boot-time system-ID check controller.
package sysid_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ID   = 3'd1,
        ST_RD_TS   = 3'd2,
        ST_BACKOFF = 3'd3,
        ST_CHECK   = 3'd4,
        ST_PASS    = 3'd5,
        ST_FAIL    = 3'd6
    } sysid_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ID      = 2'b01;
    localparam logic [1:0] ERR_TS      = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    // ID mismatch outranks timestamp mismatch when both words are wrong.
    function automatic logic [1:0] sysid_verdict(
        input logic [31:0] id_got,
        input logic [31:0] ts_got,
        input logic [31:0] id_exp,
        input logic [31:0] ts_exp
    );
        logic [1:0] v;
        if (id_got != id_exp) begin
            v = ERR_ID;
        end else if (ts_got != ts_exp) begin
            v = ERR_TS;
        end else begin
            v = ERR_NONE;
        end
        return v;
    endfunction

endpackage

// File: rtl/sysid_wait_timer.sv
// Clearable saturating stall counter; expired flags the stall cycle that
// brings the count to LIMIT. LIMIT of 0 never expires.
module sysid_wait_timer
    import sysid_check_pkg::*;
#(
    parameter int unsigned LIMIT = 32'd16
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = (LIMIT == 32'd0) ? 32'd1 : $clog2(LIMIT + 32'd1);
    localparam logic [CW-1:0] SAT  = CW'(LIMIT);
    localparam logic [CW-1:0] LAST = (LIMIT == 32'd0) ? {CW{1'b0}} : CW'(LIMIT - 32'd1);
    localparam bit ENABLED = (LIMIT != 32'd0);

    logic [CW-1:0] count_r;

    // Stall cycle counter, cleared whenever the bus is not stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else if (clr) begin
            count_r <= {CW{1'b0}};
        end else if (en && (count_r != SAT)) begin
            count_r <= count_r + CW'(1);
        end
    end

    assign expired = ENABLED && en && (count_r == LAST);

endmodule

// File: rtl/sysid_check_ctrl.sv
// Boot-time sysid checker: reads ID and timestamp over Avalon-MM and gates the
// SoC on a match. `release` is a reserved word, so the enable is soc_release.
module sysid_check_ctrl
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h5542_F8BA,
    parameter bit          AUTO_START     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 32'd16,
    parameter int unsigned MAX_RETRIES    = 32'd2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  err_code,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        soc_release
);

    localparam int unsigned RW = (MAX_RETRIES == 32'd0) ? 32'd1 : $clog2(MAX_RETRIES + 32'd1);
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRIES);

    sysid_state_t  state_r;
    logic          auto_pending_r;
    logic [RW-1:0] retry_r;
    logic          avm_read_r;
    logic          avm_address_r;
    logic          busy_r;
    logic          done_r;
    logic          pass_r;
    logic          release_r;
    logic [1:0]    err_code_r;
    logic [31:0]   id_value_r;
    logic [31:0]   ts_value_r;

    logic          stall_s;
    logic          timeout_s;
    logic [1:0]    verdict_s;

    assign stall_s   = avm_read_r && avm_waitrequest;
    assign verdict_s = sysid_verdict(id_value_r, ts_value_r, EXPECTED_ID, EXPECTED_TS);

    sysid_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .clr     (~stall_s),
        .en      (stall_s),
        .expired (timeout_s)
    );

    // Run sequencer with all outputs registered alongside the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            auto_pending_r <= AUTO_START;
            retry_r        <= {RW{1'b0}};
            avm_read_r     <= 1'b0;
            avm_address_r  <= SYSID_ADDR_ID;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            pass_r         <= 1'b0;
            release_r      <= 1'b0;
            err_code_r     <= ERR_NONE;
            id_value_r     <= 32'h0000_0000;
            ts_value_r     <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE, ST_PASS, ST_FAIL: begin
                    if (start || auto_pending_r) begin
                        state_r        <= ST_RD_ID;
                        auto_pending_r <= 1'b0;
                        retry_r        <= {RW{1'b0}};
                        avm_read_r     <= 1'b1;
                        avm_address_r  <= SYSID_ADDR_ID;
                        busy_r         <= 1'b1;
                        done_r         <= 1'b0;
                        pass_r         <= 1'b0;
                        release_r      <= 1'b0;
                        err_code_r     <= ERR_NONE;
                    end
                end
                ST_RD_ID, ST_RD_TS: begin
                    if (!avm_waitrequest) begin
                        if (state_r == ST_RD_ID) begin
                            id_value_r    <= avm_readdata;
                            state_r       <= ST_RD_TS;
                            avm_address_r <= SYSID_ADDR_TS;
                            retry_r       <= {RW{1'b0}};
                        end else begin
                            ts_value_r <= avm_readdata;
                            state_r    <= ST_CHECK;
                            avm_read_r <= 1'b0;
                        end
                    end else if (timeout_s) begin
                        avm_read_r <= 1'b0;
                        if (retry_r < RMAX) begin
                            state_r <= ST_BACKOFF;
                            retry_r <= retry_r + RW'(1);
                        end else begin
                            state_r    <= ST_FAIL;
                            err_code_r <= ERR_TIMEOUT;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
                        end
                    end
                end
                ST_BACKOFF: begin
                    // avm_address_r still names the read that timed out.
                    state_r    <= (avm_address_r == SYSID_ADDR_TS) ? ST_RD_TS : ST_RD_ID;
                    avm_read_r <= 1'b1;
                end
                ST_CHECK: begin
                    err_code_r <= verdict_s;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b1;
                    pass_r     <= (verdict_s == ERR_NONE);
                    release_r  <= (verdict_s == ERR_NONE);
                    state_r    <= (verdict_s == ERR_NONE) ? ST_PASS : ST_FAIL;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    avm_read_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign avm_read    = avm_read_r;
    assign avm_address = avm_address_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign pass        = pass_r;
    assign soc_release = release_r;
    assign err_code    = err_code_r;
    assign id_value    = id_value_r;
    assign ts_value    = ts_value_r;

endmodule
